// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer and 3x3 window scheduler for the Sobel kernel.
// Buffers three pixel rows and issues one window per centre pixel, in raster order.
module sobel_frame_ctrl #(
    parameter int ROWS = 242,
    parameter int COLS = 247,
    parameter int DW   = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            done,
    input  logic [DW-1:0]   in_pixel,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [9*DW-1:0] out_win,
    output logic            out_border,
    output logic [15:0]     out_row,
    output logic [15:0]     out_col,
    output logic            out_valid,
    input  logic            out_ready
);
    localparam int N   = ROWS * COLS;
    localparam int IW  = $clog2(N + 1);
    localparam int CW  = IW + 2;
    localparam int CAW = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state;
    logic [IW-1:0]   in_idx, out_idx;
    logic [1:0]      in_slot, o_slot;
    logic [CAW-1:0]  in_col;
    logic [15:0]     oi, oj;
    logic [DW-1:0]   mem [3][COLS];

    logic            accept, issue, is_border, have_data, last_hs;
    logic [1:0]      rs [3];
    logic [CAW-1:0]  c0;
    logic [9*DW-1:0] win_d;

    // Input may run at most COLS+2 pixels ahead of the next window, so row i-1 survives until issued.
    assign in_ready  = (state == S_RUN) && (in_idx < IW'(N)) &&
                       (CW'(in_idx) < CW'(out_idx) + CW'(COLS + 2));
    assign accept    = in_valid && in_ready;
    assign is_border = (oi == 16'd0) || (oi == 16'(ROWS - 1)) ||
                       (oj == 16'd0) || (oj == 16'(COLS - 1));
    assign have_data = CW'(in_idx) >= CW'(out_idx) + CW'(COLS + 2);
    assign issue     = (state == S_RUN) && (out_idx < IW'(N)) &&
                       (!out_valid || out_ready) && (is_border || have_data);
    assign last_hs   = (state == S_RUN) && out_valid && out_ready &&
                       (out_row == 16'(ROWS - 1)) && (out_col == 16'(COLS - 1));

    // o_slot tracks oi % 3; neighbours are the slots either side of it.
    assign rs[0] = (o_slot == 2'd0) ? 2'd2 : o_slot - 2'd1;
    assign rs[1] = o_slot;
    assign rs[2] = (o_slot == 2'd2) ? 2'd0 : o_slot + 2'd1;
    assign c0    = CAW'(oj) - CAW'(1);

    for (genvar dr = 0; dr < 3; dr++) begin : g_row
        for (genvar dc = 0; dc < 3; dc++) begin : g_col
            assign win_d[DW*(3*dr+dc) +: DW] = mem[rs[dr]][c0 + CAW'(dc)];
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            mem[in_slot][in_col] <= in_pixel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            out_valid  <= 1'b0;
            out_border <= 1'b0;
            out_win    <= '0;
            out_row    <= '0;
            out_col    <= '0;
            in_idx     <= '0;
            out_idx    <= '0;
            in_slot    <= '0;
            in_col     <= '0;
            o_slot     <= '0;
            oi         <= '0;
            oj         <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    state   <= S_RUN;
                    busy    <= 1'b1;
                    in_idx  <= '0;
                    out_idx <= '0;
                    in_slot <= '0;
                    in_col  <= '0;
                    o_slot  <= '0;
                    oi      <= '0;
                    oj      <= '0;
                end
                S_RUN: begin
                    if (accept) begin
                        in_idx <= in_idx + IW'(1);
                        if (in_col == CAW'(COLS - 1)) begin
                            in_col  <= '0;
                            in_slot <= (in_slot == 2'd2) ? 2'd0 : in_slot + 2'd1;
                        end else begin
                            in_col <= in_col + CAW'(1);
                        end
                    end
                    if (issue) begin
                        out_valid  <= 1'b1;
                        out_border <= is_border;
                        out_win    <= is_border ? '0 : win_d;
                        out_row    <= oi;
                        out_col    <= oj;
                        out_idx    <= out_idx + IW'(1);
                        if (oj == 16'(COLS - 1)) begin
                            oj     <= '0;
                            oi     <= oi + 16'd1;
                            o_slot <= (o_slot == 2'd2) ? 2'd0 : o_slot + 2'd1;
                        end else begin
                            oj <= oj + 16'd1;
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                    if (last_hs) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
